// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Holds the PC and fetches from a variable-latency instruction memory over a
// req/ready handshake. Fetched words are delivered to decode through the IF/ID
// register. Branch/jump redirects from decode take effect after exactly one
// delay-slot instruction.
//
// Ports:
//   CLOCK                        in   rising-edge clock
//   RESET                        in   synchronous, active-high reset
//   Stall_IN                     in   hazard stall, IF/ID holds while high
//   AltPC_IN[31:0]               in   redirect target from decode
//   AltPCEnable_IN               in   decode holds a taken branch/jump
//   InstrAddr_OUT[31:0]          out  fetch address (the PC register)
//   InstrReq_OUT                 out  fetch request
//   InstrReady_IN                in   memory completes the request this cycle
//   InstrData_IN[31:0]           in   fetched word, valid on req & ready
//   Instruction_OUT[31:0]        out  IF/ID instruction (bubble = 0)
//   InstructionAddressPlus4_OUT  out  IF/ID fetch address + 4 (bubble = 0)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Stall_IN,
  input  logic [31:0] AltPC_IN,
  input  logic        AltPCEnable_IN,
  output logic [31:0] InstrAddr_OUT,
  output logic        InstrReq_OUT,
  input  logic        InstrReady_IN,
  input  logic [31:0] InstrData_IN,
  output logic [31:0] Instruction_OUT,
  output logic [31:0] InstructionAddressPlus4_OUT
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } stateType;

  stateType    state;
  logic [31:0] pc;
  logic [31:0] bufInstr;
  logic [31:0] bufPc4;
  logic [31:0] pendingPc;
  logic        pendingValid;
  logic [31:0] instrReg;
  logic [31:0] pc4Reg;

  logic [31:0] pcPlus4;
  logic        fire;
  logic        redir;

  assign pcPlus4 = pc + 32'd4;

  // No request is issued while parked in HOLD or during reset, so a ready
  // seen in a reset cycle can never complete a fetch.
  assign InstrReq_OUT = (state == FETCH) & ~RESET;
  assign fire         = InstrReq_OUT & InstrReady_IN;

  // A stalled branch is still in decode next cycle; counting the redirect only
  // when decode advances keeps it from being applied twice.
  assign redir = AltPCEnable_IN & ~Stall_IN;

  assign InstrAddr_OUT               = pc;
  assign Instruction_OUT             = instrReg;
  assign InstructionAddressPlus4_OUT = pc4Reg;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      bufInstr     <= 32'h0;
      bufPc4       <= 32'h0;
      pendingPc    <= 32'h0;
      pendingValid <= 1'b0;
      instrReg     <= 32'h0;
      pc4Reg       <= 32'h0;
    end else begin
      unique case (state)
        FETCH: begin
          if (fire) begin
            // The word fetched now is the delay slot of any redirect that is
            // current or deferred, so the target becomes the next PC.
            if (redir) begin
              pc <= AltPC_IN;
            end else if (pendingValid) begin
              pc <= pendingPc;
            end else begin
              pc <= pcPlus4;
            end
            pendingValid <= 1'b0;

            if (Stall_IN) begin
              // Decode cannot take the word yet; park it and stop requesting.
              bufInstr <= InstrData_IN;
              bufPc4   <= pcPlus4;
              state    <= HOLD;
            end else begin
              instrReg <= InstrData_IN;
              pc4Reg   <= pcPlus4;
            end
          end else begin
            if (!Stall_IN) begin
              instrReg <= 32'h0;
              pc4Reg   <= 32'h0;
            end
            // The delay slot has not arrived yet; remember the target and keep
            // the PC on the delay-slot address.
            if (redir) begin
              pendingPc    <= AltPC_IN;
              pendingValid <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (!Stall_IN) begin
            instrReg <= bufInstr;
            pc4Reg   <= bufPc4;
            state    <= FETCH;
            // The buffered word is the delay slot and the PC already points
            // past it, so the target can be taken directly.
            if (redir) begin
              pc <= AltPC_IN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register directly upstream of the decode stage. Holds the PC and fetches from a variable-latency instruction memory over a req/ready handshake. Delivers `Instruction_OUT` and `InstructionAddressPlus4_OUT` to decode and honours the hazard stall. Applies branch/jump redirects (`AltPC`/`AltPCEnable` from decode) after exactly one delay-slot instruction, per MIPS semantics.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC loaded by reset.
- `CLOCK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `Stall_IN` in 1: hazard stall. When 1, the IF/ID register holds and decode keeps its current instruction.
- `AltPC_IN` in 32: redirect target from decode.
- `AltPCEnable_IN` in 1: decode's instruction is a taken branch/jump.
- `InstrAddr_OUT` out 32: fetch address; equals the PC register.
- `InstrReq_OUT` out 1: fetch request.
- `InstrReady_IN` in 1: memory accepts/completes the request this cycle.
- `InstrData_IN` in 32: instruction word; valid when `InstrReq_OUT & InstrReady_IN`.
- `Instruction_OUT` out 32: IF/ID instruction. A bubble is 32'h0 (`sll $0,$0,0`).
- `InstructionAddressPlus4_OUT` out 32: fetch address + 4 of `Instruction_OUT`. A bubble is 32'h0.

## Operation
Registers:
- `PC`: next address to fetch.
- `Buf`/`BufPC4`: one-entry holding buffer.
- `Pending`/`PendingValid`: deferred redirect.
- State: FETCH or HOLD.

Definitions:
- `fire` = `InstrReq_OUT & InstrReady_IN`.
- `redir` = `AltPCEnable_IN & ~Stall_IN`. A redirect is sampled only in the cycle the branch leaves decode, so a stalled branch is never counted twice.
- `InstrReq_OUT` = (state == FETCH) & ~`RESET`.
- `InstrAddr_OUT` and `PC` stay stable while a request waits for ready.

FETCH state:
- `Stall_IN`=0, `fire`: load IF/ID with {`InstrData_IN`, `PC`+4}; stay in FETCH.
- `Stall_IN`=0, no `fire`: load IF/ID with a bubble.
- `Stall_IN`=1, `fire`: `Buf` ← `InstrData_IN`, `BufPC4` ← `PC`+4; go to HOLD. IF/ID holds.
- `Stall_IN`=1, no `fire`: no change.
- PC on `fire`, in priority order:
  - `redir` → `AltPC_IN`. The fetched word is the delay slot.
  - else `PendingValid` → `Pending`, and clear `PendingValid`.
  - else `PC`+4.
- `redir` without `fire`: `Pending` ← `AltPC_IN`, `PendingValid` ← 1. PC is unchanged, so the delay slot is still fetched first.

HOLD state (no request issued):
- `Stall_IN`=1: hold everything.
- `Stall_IN`=0: IF/ID ← {`Buf`, `BufPC4`}; go to FETCH. If `redir`, PC ← `AltPC_IN`. The buffered word was the delay slot, and `PC` already points past it.
- `PendingValid` is never 1 in HOLD: it is consumed on the same `fire` that enters HOLD.

Arithmetic:
- PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
- No alignment checks; low two bits pass through.

## Timing
Reset:
- `PC`=`RESET_PC`, state FETCH, IF/ID = {0,0}, `PendingValid`=0.
- `InstrReq_OUT`=0 in reset cycles. The first request is in the cycle after `RESET` falls.

Latency:
- Zero-wait memory (ready=1 every cycle): one instruction per cycle; IF/ID shows a word the edge after its `fire`.
- N wait cycles: N bubbles into decode.

Redirect:
- First target fetch is issued the cycle after the delay-slot `fire` (FETCH) or after HOLD release.
- Exactly one delay-slot instruction always reaches decode.

Reset priority:
- `RESET` mid-request or mid-HOLD discards `Buf` and `Pending`.
- A concurrent ready in a reset cycle is ignored.

## Test plan
- **Reset/streaming:** `RESET_PC`=0x00400000, zero-wait memory returning addr-based words → `InstrAddr_OUT` 0x00400000, …04, …08 on consecutive cycles; IF/ID PC+4 = 0x00400004, …08, …0C.
- **Wait states:** ready low 2 cycles for 0x00400004 → address held 3 cycles, two bubbles (0/0) in IF/ID, then the word with PC+4 = 0x00400008.
- **Taken branch, fast memory:** branch at 0x00400010 in decode, `AltPC_IN`=0x00400100 → IF/ID receives 0x00400014 (delay slot), then fetch address 0x00400100.
- **Redirect during wait:** same branch while the 0x00400014 fetch is unready for 2 cycles → address stays 0x00400014 until ready, next request 0x00400100, no fetch at 0x00400018.
- **Stall with buffer:** `Stall_IN`=1 for 3 cycles while 0x00400008 fires → no request in HOLD; IF/ID unchanged; on release IF/ID gets the buffered word with PC+4 0x0040000C, next fetch 0x0040000C.
- **Stalled branch plus reset:** `AltPCEnable_IN`=1 held through 2 stall cycles → single redirect, one delay slot. Separately, `RESET` during a pending redirect → next fetch `RESET_PC`, IF/ID 0/0.
